// File: rtl/net_resolver_pkg.sv
// Shared types for the net resolver: resolution kinds and the driver-count limit.
package net_resolver_pkg;

  typedef enum logic [1:0] {
    MODE_WOR  = 2'd0,
    MODE_WAND = 2'd1,
    MODE_TRI  = 2'd2
  } mode_e;

  localparam int MAX_DRIVERS = 16;

  function automatic logic mode_ok(mode_e m);
    return (m == MODE_WOR) || (m == MODE_WAND) || (m == MODE_TRI);
  endfunction

endpackage

// File: rtl/net_resolve_lane.sv
// Resolves a single bit position across all drivers; purely combinational.
module net_resolve_lane
  import net_resolver_pkg::*;
#(
  parameter int    DRIVERS = 3,
  parameter mode_e MODE    = MODE_WOR
) (
  input  logic [DRIVERS-1:0] bits_i,
  input  logic [DRIVERS-1:0] en_i,
  input  logic               prev_i,
  output logic               value_o,
  output logic               float_o,
  output logic               contended_o
);

  logic any1;
  logic any0;
  logic tri_val;

  assign any1        = |(bits_i & en_i);
  assign any0        = |(~bits_i & en_i);
  assign float_o     = ~|en_i;
  assign contended_o = (MODE == MODE_TRI) && any1 && any0;

  // A floating or fought-over tri-state bit keeps whatever the net last held.
  assign tri_val = (float_o || contended_o) ? prev_i : any1;

  assign value_o = (MODE == MODE_WAND) ? ~any0   :
                   (MODE == MODE_TRI)  ? tri_val : any1;

endmodule

// File: rtl/net_resolver.sv
// Resolves DRIVERS packed driver values into one net value, registered once
// behind a valid/ready output stage, with a saturating contention counter.
module net_resolver
  import net_resolver_pkg::*;
#(
  parameter int    WIDTH   = 1,
  parameter int    DRIVERS = 3,
  parameter mode_e MODE    = MODE_WOR,
  parameter int    CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DRIVERS*WIDTH-1:0]   drv_data,
  input  logic [DRIVERS-1:0]         drv_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_float,
  output logic                       out_conflict,
  output logic [CNT_W-1:0]           conflict_cnt,
  input  logic                       cnt_clear
);

  localparam logic [WIDTH-1:0] DATA_RST = (MODE == MODE_WAND) ? '1 : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (DRIVERS < 1 || DRIVERS > MAX_DRIVERS || !mode_ok(MODE)) begin : g_bad_param
    $error("net_resolver: unsupported MODE or DRIVERS out of range 1..16");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_float_q, out_float_d;
  logic             out_conflict_q, out_conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] lane_val;
  logic [WIDTH-1:0] lane_float;
  logic [WIDTH-1:0] lane_cont;
  logic             xfer;
  logic             contended;

  assign in_ready  = !out_valid_q || out_ready;
  assign xfer      = in_valid && in_ready;
  assign contended = |lane_cont;

  for (genvar b = 0; b < WIDTH; b++) begin : g_lane
    logic [DRIVERS-1:0] bits;
    for (genvar k = 0; k < DRIVERS; k++) begin : g_tap
      assign bits[k] = drv_data[k*WIDTH + b];
    end
    net_resolve_lane #(
      .DRIVERS (DRIVERS),
      .MODE    (MODE)
    ) u_lane (
      .bits_i      (bits),
      .en_i        (drv_en),
      .prev_i      (out_data_q[b]),
      .value_o     (lane_val[b]),
      .float_o     (lane_float[b]),
      .contended_o (lane_cont[b])
    );
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_float_d    = out_float_q;
    out_conflict_d = out_conflict_q;
    if (xfer) begin
      out_valid_d    = 1'b1;
      out_data_d     = lane_val;
      out_float_d    = &lane_float;
      out_conflict_d = contended;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (xfer && contended && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= DATA_RST;
      out_float_q    <= 1'b0;
      out_conflict_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_float_q    <= out_float_d;
      out_conflict_q <= out_conflict_d;
      cnt_q          <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_float    = out_float_q;
  assign out_conflict = out_conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/net_resolver.md
NET_RESOLVER -- requirements
Module: net_resolver

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 1, bits per driver; DRIVERS, default 3, number of drivers, 1..16; MODE, default MODE_WOR, net resolution kind (MODE_WOR, MODE_WAND, MODE_TRI); CNT_W, default 8, conflict counter width.
REQ-002 The ports SHALL be: clk  input  1  the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  driver sample presented.
REQ-005 in_ready  output  1  sample accepted this cycle.
REQ-006 drv_data  input  DRIVERS*WIDTH  packed driver values; driver k occupies bits [k*WIDTH +: WIDTH].
REQ-007 drv_en  input  DRIVERS  per-driver enable; a disabled driver does not contribute.
REQ-008 out_valid  output  1  resolved value held.
REQ-009 out_ready  input  1  consumer accepts the value.
REQ-010 out_data  output  WIDTH  resolved net value.
REQ-011 out_float  output  1  no driver was enabled (TRI keeper active).
REQ-012 out_conflict  output  1  TRI contention occurred in this sample.
REQ-013 conflict_cnt  output  CNT_W  saturating count of contended samples.
REQ-014 cnt_clear  input  1  zeroes conflict_cnt.

Function
REQ-015 A sample transfers when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready, giving one output register and full throughput.
REQ-016 Latency SHALL be one cycle: out_* reflects the sample accepted on the previous edge.
REQ-017 out_valid SHALL set on transfer and clear on out_valid && out_ready without a new transfer; a simultaneous accept and transfer SHALL keep out_valid at 1 and load the new value.
REQ-018 In MODE_WOR, out_data SHALL be the bitwise OR of enabled drivers; with no enabled driver it SHALL be all-zero.
REQ-019 In MODE_WAND, out_data SHALL be the bitwise AND of enabled drivers; with no enabled driver it SHALL be all-one.
REQ-020 In MODE_TRI with exactly one enabled driver, out_data SHALL be that driver's value.
REQ-021 In MODE_TRI with two or more enabled drivers, a bit SHALL be contended if the enabled drivers disagree on it; contended bits SHALL resolve to the previous out_data bit, uncontended bits to the common value, and out_conflict SHALL be 1.
REQ-022 In MODE_TRI with no enabled driver, out_data SHALL hold its previous value and out_float SHALL be 1.
REQ-023 out_float and out_conflict SHALL be 0 in MODE_WOR and MODE_WAND, except that out_float SHALL be 1 when no driver is enabled.
REQ-024 conflict_cnt SHALL increment by 1 on each transferred sample with contention.
REQ-025 conflict_cnt SHALL saturate at 2^CNT_W-1.
REQ-026 cnt_clear SHALL take priority over an increment in the same cycle.
REQ-027 Output registers SHALL hold unchanged while out_valid && !out_ready.

Reset
REQ-028 On rst at a clk edge, out_valid, out_float, out_conflict and conflict_cnt SHALL be 0.
REQ-029 On rst, out_data SHALL be 0 for MODE_WOR and MODE_TRI and all-one for MODE_WAND.
REQ-030 Reset SHALL discard any held, unaccepted output.
REQ-031 in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-032 Package net_resolver_pkg SHALL hold the mode enum (MODE_WOR, MODE_WAND, MODE_TRI) and its 2-bit typedef.
REQ-033 A combinational sub-module net_resolve_lane SHALL resolve one bit position across DRIVERS inputs. It SHALL return value, float and contended, and SHALL be instantiated WIDTH times by a generate loop.
REQ-034 An unsupported MODE or a DRIVERS value outside 1..16 SHALL be rejected at elaboration.

Verification
REQ-035 WOR, WIDTH=4, DRIVERS=3: data 0001/0100/1000 with en=011 -> out_data=0101 one cycle later, out_float=0.
REQ-036 WAND, WIDTH=4: en=000 -> out_data=1111, out_float=1; then en=110 with data x/1100/0110 -> out_data=0100.
REQ-037 TRI, WIDTH=4: one driver 1010 -> 1010; then drivers 1010 and 1000 enabled -> out_data=1010, out_conflict=1, conflict_cnt=1; then en=000 -> holds 1010 with out_float=1.
REQ-038 TRI, CNT_W=2: five contended samples -> conflict_cnt=3; cnt_clear asserted with a contended sample -> conflict_cnt=0.
REQ-039 Backpressure: out_ready=0 with in_valid held for 3 cycles -> in_ready=0 after the first transfer and out_data stable; out_ready=1 with in_valid=1 -> one transfer per cycle with out_valid held at 1.
REQ-040 Reset while out_valid=1 and conflict_cnt=2 -> next cycle out_valid=0, conflict_cnt=0, in_ready=1.
